// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with busy/done/err handshakes.
// Define SEQ_GEN_LOOP_EN to add the loop input for gapless repeated passes.
module seq_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
`ifdef SEQ_GEN_LOOP_EN
  input  logic             loop,
`endif
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic {IDLE, SEND} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d, pat_sh;
  logic [LW-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic             err_q, err_d, loop_w, len_ok, accept, last;
`ifdef SEQ_GEN_LOOP_EN
  assign loop_w = loop;
`else
  assign loop_w = 1'b0;
`endif
  always_comb begin
    len_ok  = (len != '0) && (len <= LW'(WIDTH));
    accept  = (state_q == IDLE) && start && len_ok;
    last    = (state_q == SEND) && (cnt_q == '0);
    state_d = accept ? SEND : (last && !loop_w) ? IDLE : state_q;
    pat_d   = accept ? pattern : pat_q;
    len_d   = accept ? len : len_q;
    cnt_d   = accept ? len - LW'(1)
            : last ? (loop_w ? len_q - LW'(1) : '0)
            : (state_q == SEND) ? cnt_q - LW'(1) : cnt_q;
    err_d   = (state_q == IDLE) && start && !len_ok;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // Outputs decode registers only, so no input reaches them combinationally.
  assign pat_sh  = pat_q >> cnt_q;
  assign busy    = (state_q == SEND);
  assign x_valid = busy;
  assign x       = busy & pat_sh[0];
  assign done    = last;
  assign err     = err_q;
endmodule
